// File: rtl/weight_fifo_load_sched.sv
// Round-robin scheduler for weight-FIFO fill bursts over a shared memory.
// Issues FIFO_DEPTH broadcast reads, then pushes data after RD_LATENCY.
module weight_fifo_load_sched #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 2
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base,
   input  logic                            fifo_empty,
   output logic [NUM_REQ-1:0]              req_ack,
   output logic [NUM_REQ-1:0]              done,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [FIFO_WIDTH-1:0]           w_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]           w_mem_rd_addr,
   output logic [FIFO_WIDTH-1:0]           fifo_en
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CMAX = (FIFO_DEPTH > RD_LATENCY) ? FIFO_DEPTH : RD_LATENCY;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IDW-1:0]        rr_q, rr_d;
   logic [IDW-1:0]        gid_q, gid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic [RD_LATENCY-1:0] dl_q, dl_d;

   logic [ADDR_WIDTH-1:0] base_arr [NUM_REQ];
   logic [IDW-1:0]        idx, win_id;
   logic                  win_vld, grant, issue_last, drain_last;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         base_arr[i] = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Descending scan so the closest requester after rr_q is written last.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = IDW'((int'(rr_q) + i) % NUM_REQ);
         if (req_valid[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   assign grant      = (state_q == IDLE) && win_vld && fifo_empty;
   assign issue_last = (cnt_q == CW'(FIFO_DEPTH - 1));
   assign drain_last = (cnt_q == CW'(RD_LATENCY - 1));

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   if (issue_last) state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      busy_d  = busy_q;
      ack_d   = '0;
      done_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               ack_d[win_id] = 1'b1;
               gid_d   = win_id;
               addr_d  = base_arr[win_id];
               rd_en_d = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ISSUE: begin
            if (issue_last) begin
               cnt_d = '0;
            end else begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + ADDR_WIDTH'(1);
               cnt_d   = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            if (drain_last) begin
               done_d[gid_q] = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            busy_d = 1'b0;
            rr_d   = gid_q;
         end
         default: ;
      endcase
   end

   // Read-latency delay line: fifo_en mirrors rd_en RD_LATENCY cycles later.
   if (RD_LATENCY == 1) begin : g_dl1
      always_comb dl_d = rd_en_q;
   end else begin : g_dln
      always_comb dl_d = {dl_q[RD_LATENCY-2:0], rd_en_q};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q   <= '0;
         rr_q    <= IDW'(NUM_REQ - 1);
         gid_q   <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         dl_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         dl_q    <= dl_d;
      end
   end

   assign req_ack       = ack_q;
   assign done          = done_q;
   assign busy          = busy_q;
   assign grant_id      = gid_q;
   assign w_mem_rd_en   = {FIFO_WIDTH{rd_en_q}};
   assign w_mem_rd_addr = addr_q;
   assign fifo_en       = {FIFO_WIDTH{dl_q[RD_LATENCY-1]}};

endmodule

// File: tb/tb_weight_fifo_load_sched.sv
// Directed bench for weight_fifo_load_sched: vector table of single
// bursts plus sequences for round-robin, fifo_empty gating and reset.
module tb_weight_fifo_load_sched;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [31:0] req_base;
   logic        fifo_empty;
   logic [3:0]  req_ack;
   logic [3:0]  done;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] w_mem_rd_en;
   logic [7:0]  w_mem_rd_addr;
   logic [15:0] fifo_en;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         rid;
      logic [7:0] base;
      bit         chg;
      logic [7:0] nbase;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
      int         exp_gid;
   } vec_t;

   vec_t vt[5];

   int ack_id[8], ack_cyc[8], done_id[8], done_cyc[8];
   int n_ack, n_done, a, t_ack;
   bit multi;
   int exp_ord[5];
   logic [3:0] pend;

   weight_fifo_load_sched #(
      .NUM_REQ(4), .FIFO_WIDTH(16), .FIFO_DEPTH(16),
      .ADDR_WIDTH(8), .RD_LATENCY(2)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_base(req_base),
      .fifo_empty(fifo_empty),
      .req_ack(req_ack), .done(done), .busy(busy),
      .grant_id(grant_id),
      .w_mem_rd_en(w_mem_rd_en), .w_mem_rd_addr(w_mem_rd_addr),
      .fifo_en(fifo_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Requester protocol: req_valid must stay high until req_ack is seen.
   always @(posedge clk) begin
      if (!rstn) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            assert (!(pend[i] && !req_valid[i] && !req_ack[i]))
               else $error("protocol: req_valid[%0d] dropped before req_ack", i);
         end
         pend <= (pend | req_valid) & ~req_ack;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic do_reset(input logic [3:0] v);
      @(negedge clk);
      rstn = 1'b0;
      req_valid = '0;
      fifo_empty = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ack",   req_ack, 0);
      chk("rst_done",  done, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_gid",   grant_id, 0);
      chk("rst_rden",  w_mem_rd_en, 0);
      chk("rst_addr",  w_mem_rd_addr, 0);
      chk("rst_fifoen", fifo_en, 0);
      rstn = 1'b1;
      req_valid = v;
   endtask

   task automatic run_burst(input int k, input vec_t v);
      logic [3:0] oh;
      logic [7:0] ea;
      oh = 4'b0001 << v.rid;
      @(negedge clk);
      req_base = 32'h5555_5555;
      req_base[v.rid*8 +: 8] = v.base;
      req_valid = oh;
      fifo_empty = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         chk($sformatf("v%0d_ack_j%0d", k, j), req_ack, (j == 1) ? oh : 4'b0);
         chk($sformatf("v%0d_rden_j%0d", k, j), w_mem_rd_en,
             (j <= 16) ? 16'hFFFF : 16'h0);
         chk($sformatf("v%0d_fifoen_j%0d", k, j), fifo_en,
             (j >= 3 && j <= 18) ? 16'hFFFF : 16'h0);
         chk($sformatf("v%0d_done_j%0d", k, j), done, (j == 19) ? oh : 4'b0);
         chk($sformatf("v%0d_busy_j%0d", k, j), busy, (j <= 19) ? 1 : 0);
         chk($sformatf("v%0d_gid_j%0d", k, j), grant_id, v.exp_gid);
         if (j <= 16) begin
            ea = (j == 16) ? v.exp_last : v.exp_first + 8'(j - 1);
            chk($sformatf("v%0d_addr_j%0d", k, j), w_mem_rd_addr, ea);
         end
         if (j == 1) req_valid = '0;
         if (j == 2 && v.chg) req_base[v.rid*8 +: 8] = v.nbase;
      end
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = '0;
      req_base = '0;
      fifo_empty = 1'b1;

      vt[0] = '{0, 8'h10, 0, 8'h00, 8'h10, 8'h1F, 0};
      vt[1] = '{2, 8'hF8, 0, 8'h00, 8'hF8, 8'h07, 2};
      vt[2] = '{1, 8'h7F, 0, 8'h00, 8'h7F, 8'h8E, 1};
      vt[3] = '{3, 8'hFF, 0, 8'h00, 8'hFF, 8'h0E, 3};
      vt[4] = '{0, 8'h40, 1, 8'h80, 8'h40, 8'h4F, 0};
      exp_ord = '{0, 1, 2, 3, 0};

      do_reset(4'b0000);
      for (int k = 0; k < 5; k++) run_burst(k, vt[k]);

      // Round-robin with all requesters pending from reset
      req_base = {8'hC0, 8'h80, 8'h40, 8'h00};
      do_reset(4'hF);
      n_ack = 0; n_done = 0; multi = 0;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         if ($countones(req_ack) > 1 || $countones(done) > 1) multi = 1;
         if (req_ack != 0 && n_ack < 8) begin
            a = idx_of(req_ack);
            ack_id[n_ack] = a;
            ack_cyc[n_ack] = cyc;
            n_ack++;
            if (!(a == 0 && n_ack == 1)) req_valid[a] = 1'b0;
         end
         if (done != 0 && n_done < 8) begin
            done_id[n_done] = idx_of(done);
            done_cyc[n_done] = cyc;
            n_done++;
         end
      end
      chk("rr_nack", n_ack, 5);
      chk("rr_ndone", n_done, 5);
      chk("rr_onehot", multi, 0);
      for (int k = 0; k < 5 && k < n_ack; k++)
         chk($sformatf("rr_order%0d", k), ack_id[k], exp_ord[k]);
      for (int k = 1; k < n_ack; k++)
         chk($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 20);
      for (int k = 0; k < n_done && k < n_ack; k++) begin
         chk($sformatf("rr_done_id%0d", k), done_id[k], ack_id[k]);
         chk($sformatf("rr_done_lat%0d", k), done_cyc[k] - ack_cyc[k], 18);
      end

      // Reset in the middle of a burst
      req_base = {8'h60, 8'h00, 8'h00, 8'h20};
      do_reset(4'b0001);
      @(negedge clk);
      chk("mr_ack0", req_ack, 4'b0001);
      req_valid = '0;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mr_rden", w_mem_rd_en, 0);
      chk("mr_fifoen", fifo_en, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_ack", req_ack, 0);
      chk("mr_gid", grant_id, 0);
      rstn = 1'b1;
      req_valid = 4'b1001;
      @(negedge clk);
      chk("mr_reack", req_ack, 4'b0001);
      chk("mr_regid", grant_id, 0);
      t_ack = cyc;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("mr_nostray", fifo_en, 0);
      n_ack = 0; n_done = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (req_ack != 0 && n_ack < 8) begin
            a = idx_of(req_ack);
            ack_id[n_ack] = a;
            ack_cyc[n_ack] = cyc;
            n_ack++;
            req_valid[a] = 1'b0;
         end
         if (done != 0 && n_done < 8) begin
            done_id[n_done] = idx_of(done);
            done_cyc[n_done] = cyc;
            n_done++;
         end
      end
      chk("mr_ndone", n_done, 2);
      chk("mr_nack", n_ack, 1);
      if (n_done > 0) begin
         chk("mr_done_id", done_id[0], 0);
         chk("mr_done_cyc", done_cyc[0] - t_ack, 18);
      end
      if (n_ack > 0) begin
         chk("mr_ack3_id", ack_id[0], 3);
         chk("mr_ack3_cyc", ack_cyc[0] - t_ack, 20);
      end

      // Grant held off while fifo_empty is low
      @(negedge clk);
      req_base = 32'h0000_9000;
      fifo_empty = 1'b0;
      req_valid = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("fe_block%0d", c), {req_ack, w_mem_rd_en}, 0);
      end
      fifo_empty = 1'b1;
      @(negedge clk);
      chk("fe_ack", req_ack, 4'b0010);
      chk("fe_addr", w_mem_rd_addr, 8'h90);
      t_ack = cyc;
      req_valid = '0;
      fifo_empty = 1'b0;
      n_done = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done != 0 && n_done < 8) begin
            done_id[n_done] = idx_of(done);
            done_cyc[n_done] = cyc;
            n_done++;
         end
      end
      chk("fe_ndone", n_done, 1);
      if (n_done > 0) begin
         chk("fe_done_id", done_id[0], 1);
         chk("fe_done_cyc", done_cyc[0] - t_ack, 18);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
